// File: rtl/peri_sample_fifo_pkg.sv
// rtl/peri_sample_fifo_pkg.sv - register map constants and decode helper for peri_sample_fifo
package peri_sample_fifo_pkg;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h1;
  localparam logic [3:0] ADDR_CTRL   = 4'h2;
  localparam logic [3:0] ADDR_THRESH = 4'h3;

  localparam int STAT_OVF_BIT  = 7;
  localparam int STAT_UDF_BIT  = 6;
  localparam int STAT_FULL_BIT = 5;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_FLUSH_BIT = 1;

  localparam logic [4:0] THRESH_RESET = 5'd1;

  typedef enum logic [2:0] {
    REG_DATA,
    REG_STATUS,
    REG_CTRL,
    REG_THRESH,
    REG_NONE
  } reg_idx_e;

  function automatic reg_idx_e decode_addr(input logic [3:0] adr);
    case (adr)
      ADDR_DATA:   return REG_DATA;
      ADDR_STATUS: return REG_STATUS;
      ADDR_CTRL:   return REG_CTRL;
      ADDR_THRESH: return REG_THRESH;
      default:     return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/peri_sample_fifo_if.sv
// rtl/peri_sample_fifo_if.sv - Wishbone B4 peripheral bus bundle for peri_sample_fifo
interface peri_sample_fifo_if;
  logic       wb_we_i;
  logic       wb_stb_i;
  logic [3:0] wb_adr_i;
  logic [7:0] wb_dat_i;
  logic       wb_ack_o;
  logic [7:0] wb_dat_o;

  modport master (
    output wb_we_i, wb_stb_i, wb_adr_i, wb_dat_i,
    input  wb_ack_o, wb_dat_o
  );

  modport slave (
    input  wb_we_i, wb_stb_i, wb_adr_i, wb_dat_i,
    output wb_ack_o, wb_dat_o
  );
endinterface

// File: rtl/peri_sample_fifo_sync_fifo.sv
// rtl/peri_sample_fifo_sync_fifo.sv - synchronous sample FIFO with flush and level count
module sync_fifo #(
  parameter int Depth = 16,
  parameter int Width = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [Width-1:0]             wdata_i,
  output logic [Width-1:0]             rdata_o,
  output logic [$clog2(Depth+1)-1:0]   level_o,
  output logic                         full_o,
  output logic                         empty_o
);
  localparam int AW = $clog2(Depth);
  localparam int LW = $clog2(Depth+1);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             pop_eff, push_eff;

  assign full_o  = (level_q == LW'(Depth));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign pop_eff  = pop_i & ~empty_o;
  assign push_eff = push_i & (~full_o | pop_eff);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_eff) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_eff)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(push_eff) - LW'(pop_eff);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push_eff && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/peri_sample_fifo.sv
// rtl/peri_sample_fifo.sv - PDM sample FIFO with Wishbone register access and threshold irq
module peri_sample_fifo
  import peri_sample_fifo_pkg::*;
#(
  parameter int Depth = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [7:0]           sample_i,
  input  logic                 sample_valid_i,
  peri_sample_fifo_if.slave    wb,
  output logic                 irq_o
);
  localparam int LW = $clog2(Depth+1);

  logic          ack_q, ack_d;
  logic [7:0]    dat_q, dat_d;
  logic          en_q, en_d;
  logic [4:0]    thresh_q, thresh_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic          acc, wr_acc, pop, push, flush;
  logic          ovf_evt, udf_evt;
  reg_idx_e      idx;
  logic [7:0]    rd_val;
  logic [7:0]    thr_eff;

  logic [7:0]    fifo_rdata;
  logic [LW-1:0] level;
  logic          full, empty;

  assign idx    = decode_addr(wb.wb_adr_i);
  assign acc    = wb.wb_stb_i & ~ack_q;
  assign wr_acc = acc & wb.wb_we_i;
  assign pop    = acc & ~wb.wb_we_i & (idx == REG_DATA);
  assign push   = sample_valid_i & en_q;
  assign flush  = wr_acc & (idx == REG_CTRL) & wb.wb_dat_i[CTRL_FLUSH_BIT];

  assign udf_evt = pop & empty;
  assign ovf_evt = push & full & ~(pop & ~empty) & ~flush;

  sync_fifo #(.Depth(Depth), .Width(8)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (sample_i),
    .rdata_o (fifo_rdata),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    thr_eff = 8'(Depth);
    if (thresh_q == 5'd0)             thr_eff = 8'd1;
    else if (int'(thresh_q) <= Depth) thr_eff = {3'b000, thresh_q};
  end

  assign irq_o = en_q & (8'(level) >= thr_eff);

  always_comb begin
    rd_val = 8'h00;
    case (idx)
      REG_DATA:   rd_val = empty ? 8'h00 : fifo_rdata;
      REG_STATUS: begin
        rd_val[4:0]           = 5'(level);
        rd_val[STAT_FULL_BIT] = full;
        rd_val[STAT_UDF_BIT]  = udf_q;
        rd_val[STAT_OVF_BIT]  = ovf_q;
      end
      REG_CTRL:   rd_val[CTRL_EN_BIT] = en_q;
      REG_THRESH: rd_val[4:0] = thresh_q;
      default:    rd_val = 8'h00;
    endcase
  end

  // Sticky events take priority over a same-edge W1C so no event is lost.
  always_comb begin
    ack_d    = acc;
    dat_d    = acc ? rd_val : dat_q;
    en_d     = en_q;
    thresh_d = thresh_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (wr_acc) begin
      case (idx)
        REG_CTRL:   en_d = wb.wb_dat_i[CTRL_EN_BIT];
        REG_THRESH: thresh_d = wb.wb_dat_i[4:0];
        REG_STATUS: begin
          if (wb.wb_dat_i[STAT_OVF_BIT]) ovf_d = 1'b0;
          if (wb.wb_dat_i[STAT_UDF_BIT]) udf_d = 1'b0;
        end
        default: ;
      endcase
    end
    if (ovf_evt) ovf_d = 1'b1;
    if (udf_evt) udf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= 8'h00;
      en_q     <= 1'b0;
      thresh_q <= THRESH_RESET;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      en_q     <= en_d;
      thresh_q <= thresh_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;

endmodule

// File: tb/tb_peri_sample_fifo.sv
// tb/tb_peri_sample_fifo.sv - scoreboard testbench for peri_sample_fifo
module tb_peri_sample_fifo;
  import peri_sample_fifo_pkg::*;

  localparam int Depth = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sample;
  logic       sample_valid;
  logic       irq;

  peri_sample_fifo_if bus ();

  peri_sample_fifo #(.Depth(Depth)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .sample_i       (sample),
    .sample_valid_i (sample_valid),
    .wb             (bus),
    .irq_o          (irq)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q [$];
  bit         m_ovf, m_udf, m_en;
  logic [4:0] m_thr;

  function automatic logic [7:0] m_status();
    return {m_ovf, m_udf, exp_q.size() == Depth, 5'(exp_q.size())};
  endfunction

  function automatic logic m_irq();
    int t;
    t = (m_thr == 0) ? 1 : ((int'(m_thr) > Depth) ? Depth : int'(m_thr));
    return m_en && (exp_q.size() >= t);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_ovf = 0; m_udf = 0; m_en = 0; m_thr = 5'd1;
  endtask

  task automatic model_push(input logic [7:0] d);
    if (m_en) begin
      if (exp_q.size() < Depth) exp_q.push_back(d);
      else m_ovf = 1;
    end
  endtask

  task automatic model_pop(output logic [7:0] d);
    if (exp_q.size() == 0) begin
      m_udf = 1;
      d = 8'h00;
    end else d = exp_q.pop_front();
  endtask

  task automatic wb_xfer(input bit we, input logic [3:0] adr, input logic [7:0] wd,
                         output logic [7:0] rd);
    bit got = 0;
    rd = 8'hxx;
    @(negedge clk);
    bus.wb_stb_i = 1'b1; bus.wb_we_i = we; bus.wb_adr_i = adr; bus.wb_dat_i = wd;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.wb_ack_o === 1'b1) begin
        got = 1;
        rd  = bus.wb_dat_o;
      end
    end
    bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL wb_ack_timeout adr=%h: ack never seen, required 1", adr);
    end
  endtask

  task automatic rd_reg(input logic [3:0] adr, output logic [7:0] d);
    wb_xfer(1'b0, adr, 8'h00, d);
  endtask

  task automatic wr_reg(input logic [3:0] adr, input logic [7:0] d);
    logic [7:0] unused;
    wb_xfer(1'b1, adr, d, unused);
    case (adr)
      ADDR_CTRL: begin
        m_en = d[0];
        if (d[1]) exp_q.delete();
      end
      ADDR_STATUS: begin
        if (d[7]) m_ovf = 0;
        if (d[6]) m_udf = 0;
      end
      ADDR_THRESH: m_thr = d[4:0];
      default: ;
    endcase
  endtask

  task automatic push_sample(input logic [7:0] d);
    @(negedge clk);
    sample = d; sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    model_push(d);
  endtask

  // DATA read whose accepting edge coincides with a sample strobe
  task automatic pop_with_push(input logic [7:0] d, output logic [7:0] got, output logic [7:0] exp);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = ADDR_DATA;
    sample = d; sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0; bus.wb_stb_i = 1'b0;
    got = bus.wb_ack_o ? bus.wb_dat_o : 8'hxx;
    model_pop(exp);
    model_push(d);
  endtask

  task automatic test_reset();
    logic [7:0] r;
    bus.wb_stb_i = 0; bus.wb_we_i = 0; bus.wb_adr_i = 0; bus.wb_dat_i = 0;
    sample = 0; sample_valid = 0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (bus.wb_ack_o !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b expected 0", bus.wb_ack_o); end
    n_vec++; if (bus.wb_dat_o !== 8'h00) begin n_err++; $display("FAIL reset_dat: got %h expected 00", bus.wb_dat_o); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b expected 0", irq); end
    rst = 1'b0;
    rd_reg(ADDR_STATUS, r);
    n_vec++; if (r !== m_status()) begin n_err++; $display("FAIL reset_status: got %h expected %h", r, m_status()); end
    rd_reg(ADDR_THRESH, r);
    n_vec++; if (r !== 8'h01) begin n_err++; $display("FAIL reset_thresh: got %h expected 01", r); end
    rd_reg(ADDR_CTRL, r);
    n_vec++; if (r !== 8'h00) begin n_err++; $display("FAIL reset_ctrl: got %h expected 00", r); end
    push_sample(8'h99);
    rd_reg(ADDR_STATUS, r);
    n_vec++; if (r !== 8'h00) begin n_err++; $display("FAIL disabled_push_status: got %h expected 00", r); end
  endtask

  task automatic test_basic();
    logic [7:0] r, e;
    wr_reg(ADDR_CTRL, 8'h01);
    push_sample(8'h11); push_sample(8'h22); push_sample(8'h33);
    for (int i = 0; i < 3; i++) begin
      rd_reg(ADDR_DATA, r);
      model_pop(e);
      n_vec++; if (r !== e) begin n_err++; $display("FAIL basic_data[%0d]: got %h expected %h", i, r, e); end
    end
    rd_reg(ADDR_STATUS, r);
    n_vec++; if (r !== 8'h00 || r !== m_status()) begin n_err++; $display("FAIL basic_status: got %h expected 00", r); end
  endtask

  task automatic test_overflow();
    logic [7:0] r, e;
    for (int i = 0; i < 17; i++) push_sample(8'h40 + 8'(i));
    rd_reg(ADDR_STATUS, r);
    n_vec++; if (r !== 8'hB0 || r !== m_status()) begin n_err++; $display("FAIL ovf_status: got %h expected b0", r); end
    wr_reg(ADDR_STATUS, 8'h80);
    rd_reg(ADDR_STATUS, r);
    n_vec++; if (r !== 8'h30 || r !== m_status()) begin n_err++; $display("FAIL ovf_w1c_status: got %h expected 30", r); end
    for (int i = 0; i < 16; i++) begin
      rd_reg(ADDR_DATA, r);
      model_pop(e);
      n_vec++; if (r !== e) begin n_err++; $display("FAIL ovf_drain[%0d]: got %h expected %h", i, r, e); end
    end
    rd_reg(ADDR_STATUS, r);
    n_vec++; if (r !== m_status()) begin n_err++; $display("FAIL ovf_drained_status: got %h expected %h", r, m_status()); end
  endtask

  task automatic test_underflow();
    logic [7:0] r, e;
    rd_reg(ADDR_DATA, r);
    model_pop(e);
    n_vec++; if (r !== 8'h00) begin n_err++; $display("FAIL udf_data: got %h expected 00", r); end
    rd_reg(ADDR_STATUS, r);
    n_vec++; if (r !== 8'h40 || r !== m_status()) begin n_err++; $display("FAIL udf_status: got %h expected 40", r); end
    wr_reg(ADDR_STATUS, 8'h40);
    pop_with_push(8'h5A, r, e);
    n_vec++; if (r !== e) begin n_err++; $display("FAIL udf_pushpop_data: got %h expected %h", r, e); end
    rd_reg(ADDR_STATUS, r);
    n_vec++; if (r !== 8'h41 || r !== m_status()) begin n_err++; $display("FAIL udf_pushpop_status: got %h expected 41", r); end
    rd_reg(ADDR_DATA, r);
    model_pop(e);
    n_vec++; if (r !== 8'h5A) begin n_err++; $display("FAIL udf_stored_sample: got %h expected 5a", r); end
    wr_reg(ADDR_STATUS, 8'h40);
  endtask

  task automatic test_full_pushpop();
    logic [7:0] r, e;
    for (int i = 0; i < Depth; i++) push_sample(8'hA0 + 8'(i));
    pop_with_push(8'hEE, r, e);
    n_vec++; if (r !== e) begin n_err++; $display("FAIL full_pushpop_data: got %h expected %h", r, e); end
    rd_reg(ADDR_STATUS, r);
    n_vec++; if (r !== 8'h30 || r !== m_status()) begin n_err++; $display("FAIL full_pushpop_status: got %h expected 30", r); end
    for (int i = 0; i < Depth; i++) begin
      rd_reg(ADDR_DATA, r);
      model_pop(e);
      n_vec++; if (r !== e) begin n_err++; $display("FAIL full_drain[%0d]: got %h expected %h", i, r, e); end
    end
  endtask

  task automatic test_thresh();
    logic [7:0] r, e;
    wr_reg(ADDR_THRESH, 8'h04);
    for (int i = 0; i < 3; i++) push_sample(8'h60 + 8'(i));
    @(negedge clk);
    n_vec++; if (irq !== 1'b0 || irq !== m_irq()) begin n_err++; $display("FAIL thr_below: got %b expected 0", irq); end
    push_sample(8'h63);
    @(negedge clk);
    n_vec++; if (irq !== 1'b1 || irq !== m_irq()) begin n_err++; $display("FAIL thr_reached: got %b expected 1", irq); end
    rd_reg(ADDR_DATA, r);
    model_pop(e);
    @(negedge clk);
    n_vec++; if (irq !== 1'b0 || irq !== m_irq()) begin n_err++; $display("FAIL thr_after_pop: got %b expected 0", irq); end
    wr_reg(ADDR_THRESH, 8'h00);
    @(negedge clk);
    n_vec++; if (irq !== m_irq()) begin n_err++; $display("FAIL thr_zero: got %b expected %b", irq, m_irq()); end
    wr_reg(ADDR_THRESH, 8'h1F);
    while (exp_q.size() < Depth - 1) push_sample(8'h70 + 8'(exp_q.size()));
    @(negedge clk);
    n_vec++; if (irq !== 1'b0 || irq !== m_irq()) begin n_err++; $display("FAIL thr_clamp_below: got %b expected 0", irq); end
    push_sample(8'h7F);
    @(negedge clk);
    n_vec++; if (irq !== 1'b1 || irq !== m_irq()) begin n_err++; $display("FAIL thr_clamp_full: got %b expected 1", irq); end
    while (exp_q.size() > 0) begin
      rd_reg(ADDR_DATA, r);
      model_pop(e);
      n_vec++; if (r !== e) begin n_err++; $display("FAIL thr_drain: got %h expected %h", r, e); end
    end
  endtask

  task automatic test_flush();
    logic [7:0] r;
    wr_reg(ADDR_THRESH, 8'h04);
    for (int i = 0; i < 5; i++) push_sample(8'h80 + 8'(i));
    @(negedge clk);
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL flush_pre_irq: got %b expected 1", irq); end
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1; bus.wb_adr_i = ADDR_CTRL; bus.wb_dat_i = 8'h03;
    sample = 8'h77; sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    n_vec++; if (bus.wb_ack_o !== 1'b1) begin n_err++; $display("FAIL flush_ack: got %b expected 1", bus.wb_ack_o); end
    exp_q.delete(); m_en = 1;
    @(negedge clk);
    n_vec++; if (irq !== 1'b0 || irq !== m_irq()) begin n_err++; $display("FAIL flush_irq: got %b expected 0", irq); end
    rd_reg(ADDR_STATUS, r);
    n_vec++; if (r !== 8'h00 || r !== m_status()) begin n_err++; $display("FAIL flush_status: got %h expected 00", r); end
    rd_reg(ADDR_CTRL, r);
    n_vec++; if (r !== 8'h01) begin n_err++; $display("FAIL flush_ctrl: got %h expected 01", r); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] r;
    push_sample(8'hC1); push_sample(8'hC2);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = ADDR_DATA;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_vec++; if (bus.wb_ack_o !== 1'b0) begin n_err++; $display("FAIL rstmid_ack[%0d]: got %b expected 0", i, bus.wb_ack_o); end
    end
    @(negedge clk);
    rst = 1'b0; bus.wb_stb_i = 1'b0;
    model_reset();
    rd_reg(ADDR_STATUS, r);
    n_vec++; if (r !== 8'h00 || r !== m_status()) begin n_err++; $display("FAIL rstmid_status: got %h expected 00", r); end
    rd_reg(ADDR_THRESH, r);
    n_vec++; if (r !== 8'h01) begin n_err++; $display("FAIL rstmid_thresh: got %h expected 01", r); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_underflow();
    test_full_pushpop();
    test_thresh();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/peri_sample_fifo.md
PERI_SAMPLE_FIFO -- requirements
Module: peri_sample_fifo

Interface
REQ-001 SHALL have parameter Depth, default 16, the FIFO capacity in 8-bit samples; it is a power of two, 2..128.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port sample_i, input, 8 bits: PDM density sample from the microphone sampler.
REQ-005 SHALL have port sample_valid_i, input, 1 bit: one-cycle strobe qualifying sample_i (the sampler's irq pulse).
REQ-006 SHALL have ports wb_we_i, wb_stb_i (input, 1 bit), wb_adr_i (input, 4 bits), wb_dat_i (input, 8 bits): Wishbone B4 peripheral inputs.
REQ-007 SHALL have ports wb_ack_o (output, 1 bit) and wb_dat_o (output, 8 bits): Wishbone B4 peripheral outputs.
REQ-008 SHALL have port irq_o, output, 1 bit: level interrupt, FIFO at or above threshold.

Function
REQ-009 SHALL register wb_ack_o: ack is set on the edge where wb_stb_i=1 and ack=0, then cleared on the next edge, giving exactly one side effect per transaction.
REQ-010 SHALL update wb_dat_o on the same edge as ack; it holds its value otherwise.
REQ-011 SHALL decode the register map on wb_adr_i as follows: 0x0 DATA (R); 0x1 STATUS (R, W1C); 0x2 CTRL (RW); 0x3 THRESH (RW); any other address reads 0x00 and ignores writes.
REQ-012 DATA read SHALL return the head sample and pop it; on an empty FIFO it SHALL return 0x00, not pop, and set the sticky underflow bit.
REQ-013 STATUS read SHALL return [7] overflow, [6] underflow, [5] full, [4:0] level; a STATUS write SHALL clear bit 7 and/or bit 6 where the written bit is 1.
REQ-014 CTRL SHALL hold bit0 enable (reset 0); writing bit1=1 SHALL flush the FIFO (level becomes 0) and bit1 SHALL read back as 0; bits 7:2 SHALL read 0.
REQ-015 THRESH SHALL hold a 5-bit threshold in [4:0] (reset 1); a value of 0 SHALL behave as 1, and a value above Depth SHALL behave as Depth.
REQ-016 SHALL push sample_i when sample_valid_i=1 and enable=1; when enable=0, strobes SHALL be ignored without any flag change.
REQ-017 A push while full with no same-edge pop SHALL drop the sample and set the sticky overflow bit.
REQ-018 Same-edge push and pop while full SHALL both take effect: level unchanged, no overflow flag.
REQ-019 Same-edge push and pop while empty SHALL set underflow, return 0x00, and store the pushed sample: level becomes 1.
REQ-020 On a flush coinciding with a push, flush SHALL win: the sample is discarded and level becomes 0; the sticky flags are unaffected.
REQ-021 SHALL keep read and write pointers modulo Depth, wrapping without loss, and keep level in the range 0..Depth.
REQ-022 SHALL drive irq_o = enable AND (level >= effective threshold), derived only from registered state.
REQ-023 SHALL make a pushed sample readable via DATA on the first transaction starting after the push edge.

Reset
REQ-024 On rst_i=1 at a clock edge SHALL clear: level, both pointers, overflow, underflow, enable, wb_ack_o, wb_dat_o; THRESH SHALL be set to 1 and irq_o SHALL be 0.
REQ-025 Reset asserted mid-transaction SHALL abort it: no pop and no register write occur, and ack stays 0 while rst_i=1.
REQ-026 SHALL leave FIFO storage contents unreset; they are unobservable after reset because level is 0.

Structure
REQ-027 SHALL place register address constants (0x0..0x3), STATUS/CTRL bit positions and a register-index enum in a shared package, peri_sample_fifo_pkg.
REQ-028 SHALL implement storage in one sub-module, sync_fifo (parameter Depth, width 8, push/pop/flush, level/full/empty), with the Wishbone decode and flags in the top module.

Verification
REQ-029 Stimulus: reset, enable=1, push 0x11, 0x22, 0x33, then read DATA three times. Response: 0x11, 0x22, 0x33, then STATUS=0x00.
REQ-030 Stimulus: push 17 samples with Depth=16. Response: STATUS=0xB0 (overflow, full, level 16), first DATA=first sample; then write STATUS 0x80 -> STATUS=0x30.
REQ-031 Stimulus: read DATA on empty. Response: 0x00 and STATUS=0x40; then push and pop on the same edge while empty -> level=1.
REQ-032 Stimulus: THRESH=4, push 3 samples. Response: irq_o=0; after the 4th push irq_o=1 on the next cycle; after one pop irq_o=0.
REQ-033 Stimulus: fill to 5, then CTRL write 0x03 on the same edge as a push strobe. Response: level=0, irq_o=0, enable still 1.
REQ-034 Stimulus: assert rst_i during a DATA read with level=2. Response: no ack, then STATUS=0x00 and THRESH=0x01 after reset.
